// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 command arbiter.
// Optional resend support is enabled by defining PS2_CMD_RETRY_EN.
package ps2_pkg;

   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_RESEND = 8'hFE;
   localparam logic [7:0] PS2_ERROR  = 8'hFC;

   typedef enum logic [1:0] {
      STS_ACK     = 2'b00,
      STS_NACK    = 2'b01,
      STS_TIMEOUT = 2'b10,
      STS_RX_ERR  = 2'b11
   } ps2_status_e;

   typedef enum logic [2:0] {
      StIdle,
      StSend,
      StWaitSent,
      StWaitAck,
      StFinish
   } ps2_state_e;

endpackage

// File: rtl/ps2_rr_arb2.sv
// Two-way round-robin grant; on a tie the requester not granted last wins.
module ps2_rr_arb2
   import ps2_pkg::*;
(
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic [1:0] REQ,
   input  logic       ADVANCE,
   output logic       GNT_VALID,
   output logic       GNT_IDX
);

   logic last_q;

   always_comb begin
      GNT_VALID = |REQ;
      if (REQ == 2'b11) begin
         GNT_IDX = ~last_q;
      end else begin
         GNT_IDX = REQ[1];
      end
   end

   // Reset to "1 granted last" so requester 0 wins the first tie.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         last_q <= 1'b1;
      end else if (ADVANCE && GNT_VALID) begin
         last_q <= GNT_IDX;
      end
   end

endmodule

// File: rtl/ps2_cmd_arbiter.sv
// Arbitrates two PS/2 command requesters onto one transmitter/receiver pair.
// Define PS2_CMD_RETRY_EN to resend the command on a 0xFE response.
module ps2_cmd_arbiter
   import ps2_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 2500000,
   parameter int unsigned MAX_RETRY      = 3
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       REQ_0,
   input  logic       REQ_1,
   input  logic [7:0] CMD_0,
   input  logic [7:0] CMD_1,
   output logic       DONE_0,
   output logic       DONE_1,
   output logic [1:0] STATUS,
   output logic [7:0] RESP,
   output logic       SEND_BYTE,
   output logic [7:0] BYTE_TO_SEND,
   input  logic       BYTE_SENT,
   output logic       READ_ENABLE,
   input  logic [7:0] BYTE_READ,
   input  logic [1:0] BYTE_ERROR_CODE,
   input  logic       BYTE_READY,
   input  logic       STREAM_RD_EN,
   output logic       BUSY
);

   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef PS2_CMD_RETRY_EN
   localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);
   logic [RW-1:0] retry_q, retry_d;
`endif

   ps2_state_e  state_q, state_d;
   ps2_status_e status_q, status_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]  cmd_q, cmd_d;
   logic [7:0]  resp_q, resp_d;
   logic        gnt_q, gnt_d;
   logic        send_q, send_d;
   logic        rd_en_q, rd_en_d;
   logic        done0_q, done0_d;
   logic        done1_q, done1_d;
   logic        busy_q, busy_d;
   logic        arb_advance, arb_valid, arb_idx;

   ps2_rr_arb2 u_arb (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .REQ       ({REQ_1, REQ_0}),
      .ADVANCE   (arb_advance),
      .GNT_VALID (arb_valid),
      .GNT_IDX   (arb_idx)
   );

   always_comb begin
      state_d     = state_q;
      status_d    = status_q;
      tmo_d       = tmo_q;
      cmd_d       = cmd_q;
      resp_d      = resp_q;
      gnt_d       = gnt_q;
      arb_advance = 1'b0;
`ifdef PS2_CMD_RETRY_EN
      retry_d     = retry_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (arb_valid) begin
               arb_advance = 1'b1;
               gnt_d       = arb_idx;
               cmd_d       = arb_idx ? CMD_1 : CMD_0;
               state_d     = StSend;
`ifdef PS2_CMD_RETRY_EN
               retry_d     = '0;
`endif
            end
         end
         StSend: begin
            tmo_d   = '0;
            state_d = StWaitSent;
         end
         StWaitSent: begin
            if (BYTE_SENT) begin
               tmo_d   = '0;
               state_d = StWaitAck;
            end else if (tmo_q == TMO_LAST) begin
               status_d = STS_TIMEOUT;
               state_d  = StFinish;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         StWaitAck: begin
            if (BYTE_READY) begin
               state_d = StFinish;
               if (BYTE_ERROR_CODE != 2'b00) begin
                  status_d = STS_RX_ERR;
               end else begin
                  case (BYTE_READ)
                     PS2_ACK: status_d = STS_ACK;
                     PS2_RESEND: begin
`ifdef PS2_CMD_RETRY_EN
                        if (retry_q < RETRY_LAST) begin
                           retry_d = retry_q + 1'b1;
                           state_d = StSend;
                        end else begin
                           status_d = STS_NACK;
                        end
`else
                        status_d = STS_NACK;
`endif
                     end
                     PS2_ERROR: status_d = STS_NACK;
                     default:   status_d = STS_NACK;
                  endcase
               end
               // A resend keeps the previous transaction's RESP visible.
               if (state_d == StFinish) begin
                  resp_d = BYTE_READ;
               end
            end else if (tmo_q == TMO_LAST) begin
               status_d = STS_TIMEOUT;
               state_d  = StFinish;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase

      // SEND_BYTE trails the SEND state by one edge; DONE lines up with FINISH.
      send_d  = (state_q == StSend);
      done0_d = (state_d == StFinish) && !gnt_q;
      done1_d = (state_d == StFinish) && gnt_q;
      busy_d  = (state_d != StIdle);
      rd_en_d = (state_d == StIdle) ? STREAM_RD_EN : (state_d == StWaitAck);
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= StIdle;
         status_q <= STS_ACK;
         tmo_q    <= '0;
         cmd_q    <= 8'h00;
         resp_q   <= 8'h00;
         gnt_q    <= 1'b0;
         send_q   <= 1'b0;
         rd_en_q  <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         busy_q   <= 1'b0;
`ifdef PS2_CMD_RETRY_EN
         retry_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         status_q <= status_d;
         tmo_q    <= tmo_d;
         cmd_q    <= cmd_d;
         resp_q   <= resp_d;
         gnt_q    <= gnt_d;
         send_q   <= send_d;
         rd_en_q  <= rd_en_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         busy_q   <= busy_d;
`ifdef PS2_CMD_RETRY_EN
         retry_q  <= retry_d;
`endif
      end
   end

   assign DONE_0       = done0_q;
   assign DONE_1       = done1_q;
   assign STATUS       = status_q;
   assign RESP         = resp_q;
   assign SEND_BYTE    = send_q;
   assign BYTE_TO_SEND = cmd_q;
   assign READ_ENABLE  = rd_en_q;
   assign BUSY         = busy_q;

endmodule

// File: tb/tb_ps2_cmd_arbiter.sv
// Directed self-checking bench for ps2_cmd_arbiter (TIMEOUT_CYCLES=100, MAX_RETRY=3).
// Expected resend count follows PS2_CMD_RETRY_EN.
module tb_ps2_cmd_arbiter;

   localparam int unsigned TMO     = 100;
   localparam int unsigned RETRIES = 3;
`ifdef PS2_CMD_RETRY_EN
   localparam int EXP_FE_SENDS = 4;
`else
   localparam int EXP_FE_SENDS = 1;
`endif

   logic       CLK = 1'b0;
   logic       RESET_N;
   logic       REQ_0, REQ_1;
   logic [7:0] CMD_0, CMD_1;
   logic       DONE_0, DONE_1;
   logic [1:0] STATUS;
   logic [7:0] RESP;
   logic       SEND_BYTE;
   logic [7:0] BYTE_TO_SEND;
   logic       BYTE_SENT;
   logic       READ_ENABLE;
   logic [7:0] BYTE_READ;
   logic [1:0] BYTE_ERROR_CODE;
   logic       BYTE_READY;
   logic       STREAM_RD_EN;
   logic       BUSY;

   int n_cmp = 0;
   int n_bad = 0;
   int sb_cnt = 0;
   int d0_cnt = 0;
   int d1_cnt = 0;

   ps2_cmd_arbiter #(
      .TIMEOUT_CYCLES (TMO),
      .MAX_RETRY      (RETRIES)
   ) dut (
      .CLK             (CLK),
      .RESET_N         (RESET_N),
      .REQ_0           (REQ_0),
      .REQ_1           (REQ_1),
      .CMD_0           (CMD_0),
      .CMD_1           (CMD_1),
      .DONE_0          (DONE_0),
      .DONE_1          (DONE_1),
      .STATUS          (STATUS),
      .RESP            (RESP),
      .SEND_BYTE       (SEND_BYTE),
      .BYTE_TO_SEND    (BYTE_TO_SEND),
      .BYTE_SENT       (BYTE_SENT),
      .READ_ENABLE     (READ_ENABLE),
      .BYTE_READ       (BYTE_READ),
      .BYTE_ERROR_CODE (BYTE_ERROR_CODE),
      .BYTE_READY      (BYTE_READY),
      .STREAM_RD_EN    (STREAM_RD_EN),
      .BUSY            (BUSY)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (SEND_BYTE) sb_cnt <= sb_cnt + 1;
      if (DONE_0)    d0_cnt <= d0_cnt + 1;
      if (DONE_1)    d1_cnt <= d1_cnt + 1;
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic wait_send(output bit ok, output int lat);
      ok  = 1'b0;
      lat = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge CLK);
         lat++;
         if (SEND_BYTE) ok = 1'b1;
      end
   endtask

   task automatic sent_after(input int dly);
      repeat (dly) @(negedge CLK);
      BYTE_SENT = 1'b1;
      @(negedge CLK);
      BYTE_SENT = 1'b0;
   endtask

   task automatic respond(input logic [7:0] rb, input logic [1:0] re, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (READ_ENABLE) ok = 1'b1;
         else @(negedge CLK);
      end
      if (ok) begin
         BYTE_READ       = rb;
         BYTE_ERROR_CODE = re;
         BYTE_READY      = 1'b1;
         @(negedge CLK);
         BYTE_READY      = 1'b0;
         BYTE_ERROR_CODE = 2'b00;
      end
   endtask

   task automatic wait_done(input int max, output int which, output int cyc);
      which = -1;
      cyc   = 0;
      while (which < 0 && cyc < max) begin
         if (DONE_0) which = 0;
         else if (DONE_1) which = 1;
         else begin
            @(negedge CLK);
            cyc++;
         end
      end
   endtask

   task automatic serve(input int dly, input logic [7:0] rb, input logic [1:0] re,
                        input logic [7:0] exp_cmd, output int lat, output int which);
      bit ok;
      int cyc;
      wait_send(ok, lat);
      check_val("send_seen", ok, 1);
      check_val("send_cmd", BYTE_TO_SEND, exp_cmd);
      sent_after(dly);
      respond(rb, re, ok);
      check_val("ack_phase_seen", ok, 1);
      wait_done(20, which, cyc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit         ok;
      int         lat, which, cyc, base_sb, base_d0, base_d1;
      logic [4:0] pat;
      pat = 5'b01101;
      REQ_0 = 1'b0; REQ_1 = 1'b0; CMD_0 = 8'h00; CMD_1 = 8'h00;
      BYTE_SENT = 1'b0; BYTE_READ = 8'h00; BYTE_ERROR_CODE = 2'b00; BYTE_READY = 1'b0;
      STREAM_RD_EN = 1'b0;
      RESET_N = 1'b1;
      #2 RESET_N = 1'b0;
      @(negedge CLK);
      check_val("reset_outputs",
                {SEND_BYTE, BYTE_TO_SEND, READ_ENABLE, DONE_0, DONE_1, STATUS, RESP, BUSY}, 0);
      repeat (2) @(negedge CLK);
      RESET_N = 1'b1;
      @(negedge CLK);

      // Basic ACK transaction on requester 0.
      base_sb = sb_cnt; base_d0 = d0_cnt;
      CMD_0 = 8'hF4; REQ_0 = 1'b1;
      serve(10, 8'hFA, 2'b00, 8'hF4, lat, which);
      check_val("req_to_send_latency", lat, 2);
      check_val("ack_done_who", which, 0);
      check_val("ack_status", STATUS, 2'b00);
      check_val("ack_resp", RESP, 8'hFA);
      check_val("busy_in_finish", BUSY, 1);
      REQ_0 = 1'b0;
      repeat (4) @(negedge CLK);
      check_val("ack_send_pulses", sb_cnt - base_sb, 1);
      check_val("ack_done_pulses", d0_cnt - base_d0, 1);
      check_val("idle_busy", BUSY, 0);
      check_val("status_hold", STATUS, 2'b00);
      check_val("resp_hold", RESP, 8'hFA);

      // Stream read enable passes through with one cycle delay while idle.
      for (int i = 0; i < 5; i++) begin
         STREAM_RD_EN = pat[i];
         @(negedge CLK);
         check_val("idle_rd_en_follow", READ_ENABLE, pat[i]);
      end

      // Requester 1, non-ACK byte, stream enable ignored while busy.
      CMD_1 = 8'h55; REQ_1 = 1'b1; STREAM_RD_EN = 1'b1;
      wait_send(ok, lat);
      check_val("r1_send_seen", ok, 1);
      check_val("r1_send_cmd", BYTE_TO_SEND, 8'h55);
      check_val("busy_rd_en_ignored", READ_ENABLE, 0);
      check_val("r1_busy", BUSY, 1);
      STREAM_RD_EN = 1'b0;
      sent_after(3);
      respond(8'h12, 2'b00, ok);
      wait_done(20, which, cyc);
      check_val("other_done_who", which, 1);
      check_val("other_status", STATUS, 2'b01);
      check_val("other_resp", RESP, 8'h12);
      REQ_1 = 1'b0;
      repeat (3) @(negedge CLK);

      // Simultaneous requests twice: round-robin order 0,1,0,1.
      base_d0 = d0_cnt; base_d1 = d1_cnt;
      CMD_0 = 8'hA1; CMD_1 = 8'hB2;
      for (int r = 0; r < 2; r++) begin
         REQ_0 = 1'b1; REQ_1 = 1'b1;
         for (int k = 0; k < 2; k++) begin
            serve(2, 8'hFA, 2'b00, (k == 0) ? 8'hA1 : 8'hB2, lat, which);
            check_val("rr_order", which, k);
            if (which == 0) REQ_0 = 1'b0;
            else if (which == 1) REQ_1 = 1'b0;
         end
         REQ_0 = 1'b0; REQ_1 = 1'b0;
         repeat (3) @(negedge CLK);
      end
      check_val("rr_done0_count", d0_cnt - base_d0, 2);
      check_val("rr_done1_count", d1_cnt - base_d1, 2);

      // Repeated 0xFE responses.
      base_sb = sb_cnt;
      CMD_0 = 8'hED; REQ_0 = 1'b1;
      for (int i = 0; i < EXP_FE_SENDS; i++) begin
         wait_send(ok, lat);
         check_val("fe_send_seen", ok, 1);
         check_val("fe_send_cmd", BYTE_TO_SEND, 8'hED);
         sent_after(2);
         respond(8'hFE, 2'b00, ok);
      end
      wait_done(20, which, cyc);
      check_val("fe_done_who", which, 0);
      check_val("fe_status", STATUS, 2'b01);
      check_val("fe_resp", RESP, 8'hFE);
      REQ_0 = 1'b0;
      repeat (5) @(negedge CLK);
      check_val("fe_send_pulses", sb_cnt - base_sb, EXP_FE_SENDS);

      // BYTE_SENT never arrives: timeout.
      CMD_1 = 8'h3C; REQ_1 = 1'b1;
      wait_send(ok, lat);
      check_val("tmo_send_seen", ok, 1);
      wait_done(TMO + 20, which, cyc);
      check_val("tmo_done_who", which, 1);
      check_val("tmo_cycles", cyc, TMO);
      check_val("tmo_status", STATUS, 2'b10);
      REQ_1 = 1'b0;
      repeat (3) @(negedge CLK);

      // Receive error code.
      CMD_0 = 8'hF5; REQ_0 = 1'b1;
      serve(1, 8'hFA, 2'b01, 8'hF5, lat, which);
      check_val("rxerr_done_who", which, 0);
      check_val("rxerr_status", STATUS, 2'b11);
      check_val("rxerr_resp", RESP, 8'hFA);
      REQ_0 = 1'b0;
      repeat (3) @(negedge CLK);

      // Reset asserted in WAIT_ACK: immediate reset values, no DONE.
      base_d0 = d0_cnt;
      CMD_0 = 8'h66; REQ_0 = 1'b1;
      wait_send(ok, lat);
      sent_after(1);
      check_val("in_wait_ack", READ_ENABLE, 1);
      #2 RESET_N = 1'b0;
      #1;
      check_val("midreset_outputs",
                {SEND_BYTE, BYTE_TO_SEND, READ_ENABLE, DONE_0, DONE_1, STATUS, RESP, BUSY}, 0);
      @(negedge CLK);
      REQ_0 = 1'b0;
      @(negedge CLK);
      RESET_N = 1'b1;
      repeat (10) @(negedge CLK);
      check_val("midreset_no_done", d0_cnt - base_d0, 0);
      check_val("midreset_idle", BUSY, 0);

      // Pointer back to requester 0; same-cycle BYTE_SENT/BYTE_READY in WAIT_SENT.
      CMD_0 = 8'h77; CMD_1 = 8'h88; REQ_0 = 1'b1; REQ_1 = 1'b1;
      wait_send(ok, lat);
      check_val("rr_after_reset", BYTE_TO_SEND, 8'h77);
      REQ_0 = 1'b0;
      @(negedge CLK);
      BYTE_SENT = 1'b1; BYTE_READY = 1'b1; BYTE_READ = 8'hFA;
      @(negedge CLK);
      BYTE_SENT = 1'b0; BYTE_READY = 1'b0;
      check_val("sent_wins_in_wait_sent", READ_ENABLE, 1);
      respond(8'h34, 2'b00, ok);
      wait_done(20, which, cyc);
      check_val("dropped_req_done_who", which, 0);
      check_val("collide_status", STATUS, 2'b01);
      check_val("collide_resp", RESP, 8'h34);
      serve(1, 8'hFA, 2'b00, 8'h88, lat, which);
      check_val("pending_r1_done_who", which, 1);
      check_val("pending_r1_status", STATUS, 2'b00);
      REQ_1 = 1'b0;
      repeat (3) @(negedge CLK);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ps2_cmd_arbiter.md
PS2_CMD_ARBITER -- requirements
Module: ps2_cmd_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2500000, SHALL set the per-phase response timeout in CLK cycles (50 ms at 50 MHz).
REQ-002 Parameter MAX_RETRY, default 3, SHALL set the maximum number of resends after a 0xFE response.
REQ-003 Ports SHALL be: CLK in 1 (system clock); RESET_N in 1 (asynchronous active-low reset).
REQ-004 Ports SHALL be: REQ_0, REQ_1 in 1 each (command request, level, held until DONE); CMD_0, CMD_1 in 8 each (command byte).
REQ-005 Ports SHALL be: DONE_0, DONE_1 out 1 each (one-cycle completion pulse); STATUS out 2 (00 ACK, 01 NACK/other byte, 10 timeout, 11 receive error); RESP out 8 (last response byte).
REQ-006 Ports SHALL be: SEND_BYTE out 1; BYTE_TO_SEND out 8; BYTE_SENT in 1 (transmitter side).
REQ-007 Ports SHALL be: READ_ENABLE out 1; BYTE_READ in 8; BYTE_ERROR_CODE in 2; BYTE_READY in 1 (receiver side).
REQ-008 Ports SHALL be: STREAM_RD_EN in 1 (read enable from the stream reader, passed through when idle); BUSY out 1.

Function
REQ-009 The FSM SHALL have states IDLE, SEND, WAIT_SENT, WAIT_ACK, FINISH.
REQ-010 In IDLE with any REQ high, the arbiter SHALL grant one requester, latch its CMD byte and move to SEND on the next edge.
REQ-011 Simultaneous REQ_0 and REQ_1 SHALL be resolved round-robin: the requester not granted last wins; after reset, requester 0 wins.
REQ-012 SEND SHALL drive SEND_BYTE high for exactly one cycle with BYTE_TO_SEND equal to the latched byte, then move to WAIT_SENT.
REQ-013 WAIT_SENT SHALL move to WAIT_ACK on BYTE_SENT and reload the timeout counter.
REQ-014 WAIT_ACK SHALL hold READ_ENABLE high; on BYTE_READY it SHALL store BYTE_READ into RESP.
REQ-015 In WAIT_ACK, BYTE_ERROR_CODE != 00 SHALL give STATUS 11; 0xFA SHALL give 00; 0xFE SHALL be handled per REQ-026; any other byte SHALL give 01. Each outcome SHALL move to FINISH.
REQ-016 The timeout counter SHALL count in WAIT_SENT and WAIT_ACK; reaching TIMEOUT_CYCLES-1 SHALL give STATUS 10 and move to FINISH.
REQ-017 FINISH SHALL pulse the granted requester's DONE for one cycle with STATUS valid in that cycle, then return to IDLE.
REQ-018 STATUS and RESP SHALL hold their values until the next FINISH.
REQ-019 Lowering REQ after grant SHALL NOT abort the transaction; DONE SHALL still pulse.
REQ-020 A requester whose REQ is still high one cycle after its DONE SHALL be treated as a new request.
REQ-021 In IDLE, READ_ENABLE SHALL equal STREAM_RD_EN registered by one cycle; outside IDLE, STREAM_RD_EN SHALL be ignored.
REQ-022 BUSY SHALL be high in every state except IDLE.
REQ-023 BYTE_READY and BYTE_SENT arriving in the same cycle SHALL be resolved by current state only; the input not relevant to that state SHALL be ignored.
REQ-024 All outputs SHALL be registered; latency from REQ to SEND_BYTE SHALL be 2 cycles.

Reset
REQ-025 RESET_N low SHALL asynchronously force IDLE, clear the timeout and retry counters, set the round-robin pointer to favour requester 0, and drive SEND_BYTE=0, BYTE_TO_SEND=0x00, READ_ENABLE=0, DONE_0/1=0, STATUS=00, RESP=0x00, BUSY=0. Assertion mid-transaction SHALL abort with no DONE pulse.

Configuration
REQ-026 With PS2_CMD_RETRY_EN defined, 0xFE SHALL increment the retry counter and return to SEND with the same byte, up to MAX_RETRY times, then give STATUS 01. Without the macro, 0xFE SHALL give STATUS 01 immediately and the retry counter SHALL not exist.

Structure
REQ-027 Package ps2_pkg SHALL hold the response constants (ACK 0xFA, RESEND 0xFE, ERROR 0xFC), the STATUS code typedef and the FSM state enum.
REQ-028 Sub-module ps2_rr_arb2 SHALL implement the two-way round-robin grant with its pointer.

Verification
REQ-029 REQ_0=1, CMD_0=0xF4, BYTE_SENT after 10 cycles, receiver returns 0xFA -> single SEND_BYTE pulse with 0xF4, DONE_0 pulse, STATUS=00, RESP=0xFA.
REQ-030 REQ_0 and REQ_1 raised together twice in a row -> first grant 0, then 1, then 0; each request yields exactly one DONE.
REQ-031 Response 0xFE four times, macro defined, MAX_RETRY=3 -> four SEND_BYTE pulses, then STATUS=01; macro undefined -> one pulse, STATUS=01.
REQ-032 BYTE_SENT never asserted, TIMEOUT_CYCLES=100 -> DONE pulse 100 cycles after entering WAIT_SENT with STATUS=10.
REQ-033 BYTE_READY with BYTE_ERROR_CODE=01 -> STATUS=11; RESET_N pulsed low in WAIT_ACK -> all outputs at reset values, no DONE pulse.
REQ-034 IDLE with STREAM_RD_EN toggling -> READ_ENABLE follows it one cycle later; while BUSY=1 it is ignored.
